// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO blocks (read side, write side, pointers).
package async_fifo_pkg;
  localparam int D_SIZE_DFLT = 8;
  localparam int A_SIZE_DFLT = 8;
  localparam int FWFT_DEPTH  = 2;

  typedef logic [1:0] fwft_cnt_t;
endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry oldest-first holding buffer for the read-side FWFT stage; entry0 is the head.
module rd_skid_buf
  import async_fifo_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DFLT
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              push,
  input  logic [D_SIZE-1:0] push_data,
  input  logic              pop,
  output fwft_cnt_t         count,
  output logic [D_SIZE-1:0] head
);
  logic [D_SIZE-1:0] entry0_reg, entry0_next;
  logic [D_SIZE-1:0] entry1_reg, entry1_next;
  fwft_cnt_t         cnt_reg, cnt_next, cnt_after_pop;
  logic              pop_eff;

  always_comb begin
    pop_eff       = pop & (cnt_reg != 2'd0);
    cnt_after_pop = cnt_reg - {1'b0, pop_eff};
    entry0_next   = entry0_reg;
    entry1_next   = entry1_reg;
    if (pop_eff) entry0_next = entry1_reg;
    // An incoming word lands at the head when the pop just drained the buffer.
    if (push) begin
      if (cnt_after_pop == 2'd0) entry0_next = push_data;
      else                       entry1_next = push_data;
    end
    cnt_next = cnt_after_pop + {1'b0, push};
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      entry0_reg <= '0;
      entry1_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      entry0_reg <= entry0_next;
      entry1_reg <= entry1_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign count = cnt_reg;
  assign head  = entry0_reg;

  a_no_overflow: assert property (@(posedge r_clk) disable iff (r_rst)
    !(push && (cnt_after_pop == fwft_cnt_t'(FWFT_DEPTH))));
endmodule

// File: rtl/rd_fwft_stage.sv
// Read-side FWFT output stage: issues r_inc against rempty, captures registered RAM data, presents valid/ready.
module rd_fwft_stage
  import async_fifo_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DFLT,
  parameter int A_SIZE = A_SIZE_DFLT
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              rempty,
  output logic              r_inc,
  input  logic [D_SIZE-1:0] rdata,
  output logic              m_valid,
  output logic [D_SIZE-1:0] m_data,
  input  logic              m_ready,
  output logic [1:0]        m_count,
  output logic [A_SIZE:0]   rd_total
);
  logic            rempty_q_reg;
  logic            pending_reg;
  logic [A_SIZE:0] rd_total_reg;
  fwft_cnt_t       cnt;
  logic [2:0]      occ;
  logic            pop;

  assign m_valid = (cnt != 2'd0);
  assign pop     = m_valid & m_ready;
  assign occ     = {1'b0, cnt} + {2'b0, pending_reg};

  // m_ready feeds r_inc combinationally so a full buffer can refill in the same cycle it drains.
  assign r_inc = !r_rst && !rempty && !rempty_q_reg &&
                 ((occ <= 3'd1) || ((occ == 3'd2) && pop));

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      rempty_q_reg <= 1'b1;
      pending_reg  <= 1'b0;
      rd_total_reg <= '0;
    end else begin
      rempty_q_reg <= rempty;
      pending_reg  <= r_inc;
      if (pop) rd_total_reg <= rd_total_reg + 1'b1;
    end
  end

  rd_skid_buf #(.D_SIZE(D_SIZE)) u_skid (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .push      (pending_reg),
    .push_data (rdata),
    .pop       (pop),
    .count     (cnt),
    .head      (m_data)
  );

  assign m_count  = cnt;
  assign rd_total = rd_total_reg;

  a_no_inc_empty: assert property (@(posedge r_clk) disable iff (r_rst) !(r_inc && rempty));
  a_no_inc_after_empty: assert property (@(posedge r_clk) disable iff (r_rst) rempty |=> !r_inc);
  a_occ_bound: assert property (@(posedge r_clk) disable iff (r_rst) occ <= 3'd2);
  a_data_stable: assert property (@(posedge r_clk) disable iff (r_rst)
    (m_valid && !m_ready) |=> $stable(m_data));
endmodule

// File: tb/tb_rd_fwft_stage.sv
// Bench for rd_fwft_stage: behavioural FIFO model on the read port plus an in-order scoreboard on the stream.
module tb_rd_fwft_stage;
  localparam int D = 8;
  localparam int A = 8;

  logic         r_clk = 1'b0;
  logic         r_rst = 1'b1;
  logic         rempty = 1'b1;
  logic         r_inc;
  logic [D-1:0] rdata = '0;
  logic         m_valid;
  logic [D-1:0] m_data;
  logic         m_ready = 1'b0;
  logic [1:0]   m_count;
  logic [A:0]   rd_total;

  rd_fwft_stage #(.D_SIZE(D), .A_SIZE(A)) dut (
    .r_clk    (r_clk),
    .r_rst    (r_rst),
    .rempty   (rempty),
    .r_inc    (r_inc),
    .rdata    (rdata),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .m_count  (m_count),
    .rd_total (rd_total)
  );

  always #5 r_clk = ~r_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [D-1:0] fifo_q[$];
  logic [D-1:0] exp_q[$];

  logic         inc_s = 1'b0;
  int           inc_cnt, first_inc, last_inc;
  int           pop_cnt, first_pop, last_pop;
  logic [A:0]   tb_total = '0;
  logic         prev_hold = 1'b0;
  logic [D-1:0] prev_data = '0;

  always @(posedge r_clk) cyc = cyc + 1;

  // FIFO model: registered empty flag and registered RAM output, updated just after each edge.
  always @(posedge r_clk) begin
    #1;
    if (r_rst) begin
      rempty = 1'b1;
    end else begin
      if (inc_s) begin
        n_checks++;
        if (fifo_q.size() == 0) begin
          n_fail++;
          $display("FAIL underflow: r_inc=1 with model FIFO holding 0 words, required rempty to block it");
        end else begin
          rdata = fifo_q.pop_front();
        end
      end
      rempty = (fifo_q.size() == 0);
    end
  end

  // Stream monitor and scoreboard, sampled on the falling edge.
  always @(negedge r_clk) begin
    if (r_rst) begin
      inc_s     = 1'b0;
      prev_hold = 1'b0;
    end else begin
      inc_s = r_inc;
      n_checks++;
      if (r_inc && rempty) begin
        n_fail++;
        $display("FAIL inc_while_empty: r_inc=%0b rempty=%0b, required r_inc=0", r_inc, rempty);
      end
      if (r_inc) begin
        if (inc_cnt == 0) first_inc = cyc;
        last_inc = cyc;
        inc_cnt++;
      end
      if (prev_hold) begin
        n_checks++;
        if (!m_valid || m_data !== prev_data) begin
          n_fail++;
          $display("FAIL hold_stable: m_valid=%0b m_data=%02h, required m_valid=1 m_data=%02h",
                   m_valid, m_data, prev_data);
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && m_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: delivered %02h, required no word", m_data);
        end else begin
          logic [D-1:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_fail++;
            $display("FAIL sb_order: delivered %02h, required %02h", m_data, e);
          end
        end
        if (pop_cnt == 0) first_pop = cyc;
        last_pop = cyc;
        pop_cnt++;
        tb_total = tb_total + 1'b1;
      end
    end
  end

  task automatic drive_step();
    @(posedge r_clk);
    #2;
  endtask

  task automatic clear_stats();
    inc_cnt = 0; first_inc = 0; last_inc = 0;
    pop_cnt = 0; first_pop = 0; last_pop = 0;
  endtask

  task automatic load_word(input logic [D-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    for (int i = 0; i < budget && pop_cnt < target; i++) drive_step();
    n_checks++;
    if (pop_cnt != target) begin
      n_fail++;
      $display("FAIL %s_timeout: popped %0d words, required %0d", name, pop_cnt, target);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (r_inc !== 1'b0 || m_valid !== 1'b0 || m_count !== 2'd0 || rd_total !== '0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_values: r_inc=%0b m_valid=%0b m_count=%0d rd_total=%0d m_data=%02h, required all 0",
               r_inc, m_valid, m_count, rd_total, m_data);
    end
    repeat (3) drive_step();
    r_rst = 1'b0;
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      @(negedge r_clk);
      n_checks++;
      if (r_inc !== 1'b0 || m_valid !== 1'b0 || m_count !== 2'd0) begin
        n_fail++;
        $display("FAIL idle_empty: cycle %0d r_inc=%0b m_valid=%0b m_count=%0d, required 0/0/0",
                 i, r_inc, m_valid, m_count);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    drive_step();
    clear_stats();
    m_ready = 1'b0;
    load_word(8'hA5);
    @(posedge r_clk);                 // edge N: rempty falls
    repeat (2) @(posedge r_clk);      // edge N+2
    @(negedge r_clk);
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: m_valid=%0b before edge N+3, required 0", m_valid);
    end
    @(negedge r_clk);                 // after edge N+3
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_latency: m_valid=%0b m_data=%02h, required 1/a5", m_valid, m_data);
    end
    drive_step();
    m_ready = 1'b1;
    drive_step();
    m_ready = 1'b0;
    n_checks++;
    if (rd_total !== 9'd1 || m_count !== 2'd0 || inc_cnt != 1) begin
      n_fail++;
      $display("FAIL single_pop: rd_total=%0d m_count=%0d incs=%0d, required 1/0/1", rd_total, m_count, inc_cnt);
    end
    $display("test_single: done");
  endtask

  task automatic test_burst_ready();
    repeat (4) drive_step();
    clear_stats();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) load_word(8'(i));
    wait_pops(16, 100, "burst_ready");
    repeat (4) drive_step();
    n_checks++;
    if (last_pop - first_pop != 15 || inc_cnt != 16 || last_inc - first_inc != 15) begin
      n_fail++;
      $display("FAIL burst_rate: pop span %0d incs %0d inc span %0d, required 15/16/15",
               last_pop - first_pop, inc_cnt, last_inc - first_inc);
    end
    n_checks++;
    if (rd_total !== tb_total || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL burst_total: rd_total=%0d left=%0d, required %0d/0", rd_total, exp_q.size(), tb_total);
    end
    $display("test_burst_ready: done");
  endtask

  task automatic test_burst_stall();
    drive_step();
    clear_stats();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) load_word(8'(i));
    repeat (20) drive_step();
    n_checks++;
    if (inc_cnt != 2 || m_count !== 2'd2 || m_valid !== 1'b1 || m_data !== 8'h01 || r_inc !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_full: incs=%0d m_count=%0d m_valid=%0b m_data=%02h r_inc=%0b, required 2/2/1/01/0",
               inc_cnt, m_count, m_valid, m_data, r_inc);
    end
    m_ready = 1'b1;
    wait_pops(8, 100, "stall_drain");
    repeat (4) drive_step();
    n_checks++;
    if (exp_q.size() != 0 || m_count !== 2'd0 || rd_total !== tb_total) begin
      n_fail++;
      $display("FAIL stall_drain: left=%0d m_count=%0d rd_total=%0d, required 0/0/%0d",
               exp_q.size(), m_count, rd_total, tb_total);
    end
    m_ready = 1'b0;
    $display("test_burst_stall: done");
  endtask

  task automatic test_random();
    int pushed = 0;
    drive_step();
    clear_stats();
    for (int i = 0; i < 8000 && pop_cnt < 600; i++) begin
      drive_step();
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 600 && $urandom_range(0, 3) != 0) begin
        load_word(8'($urandom));
        pushed++;
      end
    end
    n_checks++;
    if (pop_cnt != 600) begin
      n_fail++;
      $display("FAIL random_timeout: popped %0d words, required 600", pop_cnt);
    end
    m_ready = 1'b0;
    repeat (4) drive_step();
    n_checks++;
    if (rd_total !== tb_total || tb_total !== 9'd113) begin
      n_fail++;
      $display("FAIL random_total: rd_total=%0d model=%0d, required 113 after wrap", rd_total, tb_total);
    end
    $display("test_random: done");
  endtask

  task automatic test_reset_mid();
    int i;
    drive_step();
    clear_stats();
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) load_word(8'h30 + 8'(k));
    for (i = 0; i < 50 && m_count !== 2'd1; i++) drive_step();
    n_checks++;
    if (m_count !== 2'd1) begin
      n_fail++;
      $display("FAIL rst_setup: m_count=%0d, required 1 with a word in flight", m_count);
    end
    r_rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    tb_total = '0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_count !== 2'd0 || rd_total !== '0 || r_inc !== 1'b0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL rst_async: m_valid=%0b m_count=%0d rd_total=%0d r_inc=%0b m_data=%02h, required all 0",
               m_valid, m_count, rd_total, r_inc, m_data);
    end
    repeat (3) drive_step();
    r_rst = 1'b0;
    drive_step();
    clear_stats();
    m_ready = 1'b1;
    load_word(8'h77);
    load_word(8'h78);
    wait_pops(2, 50, "rst_refetch");
    repeat (4) drive_step();
    n_checks++;
    if (rd_total !== 9'd2 || exp_q.size() != 0 || m_count !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_refetch: rd_total=%0d left=%0d m_count=%0d, required 2/0/0",
               rd_total, exp_q.size(), m_count);
    end
    $display("test_reset_mid: done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_ready();
    test_burst_stall();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
